// File: rtl/ram_sp_param.sv
// ram_sp_param: parametrised single-port RAM with byte enables, 1/2-cycle read latency,
// a read-valid strobe and a clear sequencer that zeroes the array after reset or on request.
module ram_sp_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_in,
    input  logic              re_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W/8-1:0] be_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              clr_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rvalid_out,
    output logic              ready_out,
    output logic              err_out
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q, err_q, rvalid_q, p_vld_q;
    logic [DATA_W-1:0] rdata_q, p_data_q, rd_data_d;
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic              run, wr_acc, rd_acc;

    // A clear request takes priority over and suppresses any same-cycle access.
    assign run       = state_q == RUN;
    assign wr_acc    = run && we_in && !clr_in;
    assign rd_acc    = run && re_in && !we_in && !clr_in;
    assign rd_data_d = mem[addr_in];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLR_ON_RST != 0 ? CLEAR : RUN;
            ready_q  <= CLR_ON_RST == 0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            p_vld_q  <= 1'b0;
            p_data_q <= '0;
        end else begin
            if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            end else if (clr_in) begin
                state_q <= CLEAR;
                ready_q <= 1'b0;
                cnt_q   <= '0;
            end
            if (wr_acc && re_in) err_q <= 1'b1;
            p_vld_q <= rd_acc;
            if (rd_acc) p_data_q <= rd_data_d;
            // Second pipeline stage only exists in the datapath when RD_LAT is 2.
            if (RD_LAT == 2) begin
                rvalid_q <= p_vld_q;
                if (p_vld_q) rdata_q <= p_data_q;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= rd_data_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (rst && wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (be_in[i]) mem[addr_in][8*i +: 8] <= wdata_in[8*i +: 8];
        end
    end

    assign rdata_out  = rdata_q;
    assign rvalid_out = rvalid_q;
    assign ready_out  = ready_q;
    assign err_out    = err_q;
endmodule
